// File: rtl/lfsr_feedback_solver_if.sv
// Sample/result bundle between a 2-bit shift-sequence source and the feedback solver.
// The source side drives clear and samples; the solver side returns its candidate state.
interface lfsr_feedback_solver_if #(
    parameter int unsigned CNT_W = 8
);
    logic             clear;
    logic             in_valid;
    logic [1:0]       in_data;
    logic [15:0]      cand_mask;
    logic             locked;
    logic [3:0]       func_idx;
    logic             pred_valid;
    logic [1:0]       pred_data;
    logic             shift_err;
    logic             consistent;
    logic [CNT_W-1:0] sample_cnt;

    modport master (
        output clear, in_valid, in_data,
        input  cand_mask, locked, func_idx, pred_valid, pred_data, shift_err, consistent,
               sample_cnt
    );

    modport slave (
        input  clear, in_valid, in_data,
        output cand_mask, locked, func_idx, pred_valid, pred_data, shift_err, consistent,
               sample_cnt
    );
endinterface

// File: rtl/lfsr_feedback_solver.sv
// Brute-force identifier for the feedback function of a 2-bit shift-style generator:
// prunes the 16 truth tables against observed transitions and predicts the next sample.
module lfsr_feedback_solver #(
    parameter int unsigned CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    lfsr_feedback_solver_if.slave bus
);
    typedef enum logic [1:0] {StEmpty, StTrack, StFail} state_e;

    state_e           r_state, w_state_nxt;
    logic [15:0]      r_mask, w_mask_nxt, w_filt;
    logic [1:0]       r_prev, w_prev_nxt;
    logic             r_shift_err, w_shift_err_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             w_any0, w_any1;
    logic [4:0]       w_ones;
    logic [3:0]       w_idx;

    // Candidate k's output for input j is bit j of k.
    function automatic logic tt_bit(input int k, input logic [1:0] j);
        logic [3:0] t;
        t = k[3:0];
        return t[j];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StEmpty;
            r_mask      <= 16'hFFFF;
            r_prev      <= 2'b00;
            r_shift_err <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mask      <= w_mask_nxt;
            r_prev      <= w_prev_nxt;
            r_shift_err <= w_shift_err_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_mask_nxt      = r_mask;
        w_prev_nxt      = r_prev;
        w_shift_err_nxt = r_shift_err;
        w_cnt_nxt       = r_cnt;
        w_filt          = r_mask;
        for (int k = 0; k < 16; k++) begin
            w_filt[k] = r_mask[k] & (tt_bit(k, r_prev) == bus.in_data[0]);
        end

        if (bus.clear) begin
            w_state_nxt     = StEmpty;
            w_mask_nxt      = 16'hFFFF;
            w_prev_nxt      = 2'b00;
            w_shift_err_nxt = 1'b0;
            w_cnt_nxt       = '0;
        end else if (bus.in_valid && (r_state != StFail)) begin
            w_prev_nxt = bus.in_data;
            if (r_cnt != '1) begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
            case (r_state)
                StEmpty: w_state_nxt = StTrack;
                StTrack: begin
                    // The high bit of every sample must be the previous low bit.
                    if (bus.in_data[1] != r_prev[0]) begin
                        w_shift_err_nxt = 1'b1;
                        w_state_nxt     = StFail;
                    end else begin
                        w_mask_nxt = w_filt;
                        if (w_filt == 16'h0000) begin
                            w_state_nxt = StFail;
                        end
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        w_any0 = 1'b0;
        w_any1 = 1'b0;
        w_ones = '0;
        w_idx  = '0;
        for (int k = 15; k >= 0; k--) begin
            if (r_mask[k]) begin
                w_idx = 4'(k);
                if (tt_bit(k, r_prev)) w_any1 = 1'b1;
                else                   w_any0 = 1'b1;
            end
            w_ones = w_ones + 5'(r_mask[k]);
        end
    end

    always_comb begin
        bus.cand_mask  = r_mask;
        bus.func_idx   = w_idx;
        bus.locked     = (w_ones == 5'd1) && (r_state != StFail);
        bus.pred_valid = (r_state == StTrack) && (w_any0 != w_any1);
        bus.pred_data  = bus.pred_valid ? {r_prev[0], w_any1} : 2'b00;
        bus.shift_err  = r_shift_err;
        bus.consistent = (r_mask != 16'h0000) && !r_shift_err;
        bus.sample_cnt = r_cnt;
    end
endmodule

// File: tb/tb_lfsr_feedback_solver.sv
// Bench for lfsr_feedback_solver: directed scenarios plus randomized streams, scored against
// a history-based model that re-tests every truth table against all recorded transitions.
module tb_lfsr_feedback_solver;
    logic clk;
    logic rst;

    lfsr_feedback_solver_if #(.CNT_W(8)) bus ();
    lfsr_feedback_solver_if #(.CNT_W(2)) bus2 ();

    lfsr_feedback_solver #(.CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    lfsr_feedback_solver #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    typedef struct packed {
        logic [15:0] mask;
        logic        locked;
        logic [3:0]  idx;
        logic        pv;
        logic [1:0]  pd;
        logic        err;
        logic        cons;
        logic [7:0]  cnt;
    } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    // Model state: observation history rather than a running mask.
    bit       m_have, m_fail, m_err;
    bit [1:0] m_prev;
    int       m_cnt;
    int       m_tj[$];
    int       m_tb[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic bit alive(input int k);
        foreach (m_tj[i]) begin
            if (((k >> m_tj[i]) & 1) != m_tb[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void model_reset();
        m_have = 0; m_fail = 0; m_err = 0; m_prev = 0; m_cnt = 0;
        m_tj.delete();
        m_tb.delete();
    endfunction

    function automatic void model_update(input bit v, input bit [1:0] d, input bit c);
        int n;
        if (c) begin
            model_reset();
            return;
        end
        if (!v || m_fail) return;
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        if (m_have) begin
            if (d[1] != m_prev[0]) begin
                m_err  = 1;
                m_fail = 1;
            end else begin
                m_tj.push_back(int'(m_prev));
                m_tb.push_back(int'(d[0]));
                n = 0;
                for (int k = 0; k < 16; k++) if (alive(k)) n++;
                if (n == 0) m_fail = 1;
            end
        end
        m_have = 1;
        m_prev = d;
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        int   n;
        bit   seen0, seen1;
        e = '0;
        n = 0; seen0 = 0; seen1 = 0;
        for (int k = 15; k >= 0; k--) begin
            if (alive(k)) begin
                e.mask[k] = 1'b1;
                e.idx     = 4'(k);
                n++;
                if (((k >> m_prev) & 1) == 1) seen1 = 1; else seen0 = 1;
            end
        end
        e.locked = (n == 1) && !m_fail;
        e.pv     = m_have && !m_fail && (seen0 != seen1);
        e.pd     = e.pv ? {m_prev[0], seen1} : 2'b00;
        e.err    = m_err;
        e.cons   = (n != 0) && !m_err;
        e.cnt    = 8'(m_cnt);
        return e;
    endfunction

    task automatic cmp_all(input string tag, input exp_t e);
        chk({tag, "_mask"},   32'(bus.cand_mask),  32'(e.mask));
        chk({tag, "_locked"}, 32'(bus.locked),     32'(e.locked));
        if (e.locked) chk({tag, "_idx"}, 32'(bus.func_idx), 32'(e.idx));
        chk({tag, "_pv"},     32'(bus.pred_valid), 32'(e.pv));
        chk({tag, "_pd"},     32'(bus.pred_data),  32'(e.pd));
        chk({tag, "_err"},    32'(bus.shift_err),  32'(e.err));
        chk({tag, "_cons"},   32'(bus.consistent), 32'(e.cons));
        chk({tag, "_cnt"},    32'(bus.sample_cnt), 32'(e.cnt));
    endtask

    // Monitor: one expected snapshot per issued cycle, compared on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) cmp_all("sb", exp_q.pop_front());
    end

    task automatic step(input bit v, input bit [1:0] d, input bit c);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.clear    = c;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.clear    = 1'b0;
        model_update(v, d, c);
        exp_q.push_back(model_exp());
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_mask"}, 32'(bus.cand_mask),  32'hFFFF);
        chk({tag, "_cons"}, 32'(bus.consistent), 32'd1);
        chk({tag, "_lock"}, 32'(bus.locked),     32'd0);
        chk({tag, "_pv"},   32'(bus.pred_valid), 32'd0);
        chk({tag, "_pd"},   32'(bus.pred_data),  32'd0);
        chk({tag, "_err"},  32'(bus.shift_err),  32'd0);
        chk({tag, "_cnt"},  32'(bus.sample_cnt), 32'd0);
        chk({tag, "_idx"},  32'(bus.func_idx),   32'd0);
    endtask

    initial begin
        bit [1:0] s;
        bit [3:0] f;
        bit [1:0] d;
        int       len;
        bus.clear = 0; bus.in_valid = 0; bus.in_data = 0;
        bus2.clear = 0; bus2.in_valid = 0; bus2.in_data = 0;
        model_reset();
        rst = 1'b1;
        #2;
        check_reset_vals("rst_async");
        #20;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals("rst_idle");

        // XNOR stream
        step(1, 2'b00, 0); step(1, 2'b01, 0); step(1, 2'b10, 0); step(1, 2'b00, 0);
        chk("xnor_mask", 32'(bus.cand_mask), 32'h0202);
        chk("xnor_lock", 32'(bus.locked), 32'd0);
        chk("xnor_cnt", 32'(bus.sample_cnt), 32'd4);
        chk("xnor_pv", 32'(bus.pred_valid), 32'd1);
        chk("xnor_pd", 32'(bus.pred_data), 32'd1);
        drain();

        // Mid-stream asynchronous reset between edges
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_vals("rst_mid");
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Full coverage of all four inputs locks onto function 3
        step(1, 2'b00, 0); step(1, 2'b01, 0); step(1, 2'b11, 0); step(1, 2'b10, 0);
        step(1, 2'b00, 0);
        chk("lock_mask", 32'(bus.cand_mask), 32'h0008);
        chk("lock_lock", 32'(bus.locked), 32'd1);
        chk("lock_idx", 32'(bus.func_idx), 32'd3);
        chk("lock_pv", 32'(bus.pred_valid), 32'd1);
        chk("lock_pd", 32'(bus.pred_data), 32'd1);

        // Shift-rule violation is sticky and freezes the counter
        step(0, 2'b00, 1);
        step(1, 2'b00, 0); step(1, 2'b11, 0);
        chk("shift_err", 32'(bus.shift_err), 32'd1);
        chk("shift_cons", 32'(bus.consistent), 32'd0);
        chk("shift_mask", 32'(bus.cand_mask), 32'hFFFF);
        chk("shift_cnt", 32'(bus.sample_cnt), 32'd2);
        step(1, 2'b10, 0); step(1, 2'b01, 0);
        chk("shift_frozen", 32'(bus.sample_cnt), 32'd2);

        // Contradiction empties the mask; clear beats in_valid
        step(0, 2'b00, 1);
        step(1, 2'b00, 0); step(1, 2'b01, 0); step(1, 2'b10, 0); step(1, 2'b00, 0);
        step(1, 2'b00, 0);
        chk("empty_mask", 32'(bus.cand_mask), 32'h0000);
        chk("empty_cons", 32'(bus.consistent), 32'd0);
        chk("empty_pv", 32'(bus.pred_valid), 32'd0);
        step(1, 2'b01, 0);
        chk("empty_frozen", 32'(bus.sample_cnt), 32'd5);
        step(1, 2'b00, 1);
        check_reset_vals("clr_valid");

        // Gaps between samples are not counted
        step(1, 2'b00, 0); step(0, 2'b11, 0); step(0, 2'b01, 0); step(1, 2'b00, 0);
        chk("gap_mask", 32'(bus.cand_mask), 32'h5555);
        chk("gap_cnt", 32'(bus.sample_cnt), 32'd2);

        // Narrow counter saturates
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus2.in_valid = 1'b1;
            bus2.in_data  = (i % 3 == 0) ? 2'b00 : ((i % 3 == 1) ? 2'b01 : 2'b10);
        end
        @(negedge clk);
        bus2.in_valid = 1'b0;
        chk("sat_cnt", 32'(bus2.sample_cnt), 32'd3);
        chk("sat_mask", 32'(bus2.cand_mask), 32'h0202);

        // Randomized generator streams with gaps, corruption and clears
        for (int b = 0; b < 60; b++) begin
            step($urandom_range(3) == 0, 2'($urandom), 1);
            f   = 4'($urandom);
            s   = 2'($urandom);
            len = $urandom_range(2, 14);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(4) == 0) begin
                    step(0, 2'($urandom), 0);
                end else if ($urandom_range(15) == 0) begin
                    step(1, 2'($urandom), 0);
                end else begin
                    step(1, s, 0);
                    d = {s[0], f[s]};
                    s = d;
                end
            end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
